// File: rtl/gearbox_pkg.sv
// Shared helpers for the parametrised gearbox: counter sizing and parameter legality.
package gearbox_pkg;

  function automatic int unsigned cnt_width(input int unsigned buf_w);
    return $clog2(buf_w + 1);
  endfunction

  function automatic bit params_legal(input int unsigned in_w, input int unsigned out_w,
                                      input int unsigned buf_w);
    return (in_w >= 1) && (out_w >= 1) && (buf_w >= in_w + out_w);
  endfunction

endpackage

// File: rtl/gearbox_flags.sv
// Sticky overflow/underflow error flags, cleared only by reset.
module gearbox_flags (
  input  logic clk,
  input  logic res_n,
  input  logic push_rej,
  input  logic pop_rej,
  output logic overflow,
  output logic underflow
);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_rej) overflow  <= 1'b1;
      if (pop_rej)  underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/gearbox_param.sv
// Parametrised IN_W -> OUT_W width converter built on a bit buffer and fill counter.
module gearbox_param
  import gearbox_pkg::*;
#(
  parameter  int unsigned IN_W  = 16,
  parameter  int unsigned OUT_W = 20,
  parameter  int unsigned BUF_W = 80,
  localparam int unsigned CNT_W = cnt_width(BUF_W)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             full,
  input  logic             shift_out,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             flush,
  output logic [CNT_W-1:0] fill_level,
  output logic             overflow,
  output logic             underflow
);

  if (!params_legal(IN_W, OUT_W, BUF_W)) begin : g_bad_params
    $error("gearbox_param: need IN_W>=1, OUT_W>=1, BUF_W>=IN_W+OUT_W");
  end

  localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(BUF_W - IN_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] in_ext;
  logic             push_ok, pop_ok, push_rej, pop_rej, do_flush;

  // Status decodes depend on registered state only; no path from inputs.
  assign valid_out  = (cnt_q >= OUT_C);
  assign full       = (cnt_q > FULL_TH);
  assign data_out   = buf_q[OUT_W-1:0];
  assign fill_level = cnt_q;
  assign in_ext     = BUF_W'(data_in);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // Merge network: bits above cnt are always zero, so OR-insertion is safe.
  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    push_ok  = shift_in && !full;
    pop_ok   = shift_out && valid_out;
    push_rej = shift_in && full;
    pop_rej  = shift_out && !valid_out;
    do_flush = flush && !shift_in && !shift_out && (cnt_q != '0) && (cnt_q < OUT_C);
    case ({push_ok, pop_ok})
      2'b10: begin
        buf_d = buf_q | (in_ext << cnt_q);
        cnt_d = cnt_q + IN_C;
      end
      2'b01: begin
        buf_d = buf_q >> OUT_W;
        cnt_d = cnt_q - OUT_C;
      end
      2'b11: begin
        buf_d = (buf_q >> OUT_W) | (in_ext << (cnt_q - OUT_C));
        cnt_d = cnt_q + IN_C - OUT_C;
      end
      default: begin
        if (do_flush) cnt_d = OUT_C;
      end
    endcase
  end

  gearbox_flags u_flags (
    .clk       (clk),
    .res_n     (res_n),
    .push_rej  (push_rej),
    .pop_rej   (pop_rej),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule

// File: tb/tb_gearbox_param.sv
// Directed bench for gearbox_param at IN_W=16, OUT_W=20, BUF_W=80.
module tb_gearbox_param;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        shift_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        full;
  logic        shift_out = 1'b0;
  logic [19:0] data_out;
  logic        valid_out;
  logic        flush = 1'b0;
  logic [6:0]  fill_level;
  logic        overflow;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gearbox_param #(.IN_W(16), .OUT_W(20), .BUF_W(80)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .shift_in   (shift_in),
    .data_in    (data_in),
    .full       (full),
    .shift_out  (shift_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .flush      (flush),
    .fill_level (fill_level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
  endtask

  task automatic push(input logic [15:0] d);
    shift_in = 1'b1;
    data_in  = d;
    tick();
    shift_in = 1'b0;
  endtask

  task automatic pop();
    shift_out = 1'b1;
    tick();
    shift_out = 1'b0;
  endtask

  task automatic test_reset();
    res_n    = 1'b0;
    shift_in = 1'b1;
    data_in  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (fill_level !== 7'd0) begin n_err++; $display("FAIL reset_fill[%0d]: got %0d want 0", i, fill_level); end
    end
    n_vec++;
    if ({full, valid_out, overflow, underflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {full, valid_out, overflow, underflow});
    end
    n_vec++;
    if (data_out !== 20'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000", data_out); end
    shift_in = 1'b0;
    res_n    = 1'b1;
  endtask

  task automatic test_packing();
    do_reset();
    push(16'h4321);
    n_vec++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL pack_valid16: got %b want 0", valid_out); end
    push(16'h8765);
    n_vec++;
    if (data_out !== 20'h54321 || valid_out !== 1'b1 || fill_level !== 7'd32) begin
      n_err++; $display("FAIL pack_first: got %h/%b/%0d want 54321/1/32", data_out, valid_out, fill_level);
    end
    pop();
    n_vec++;
    if (data_out !== 20'h00876 || valid_out !== 1'b0 || fill_level !== 7'd12) begin
      n_err++; $display("FAIL pack_pop: got %h/%b/%0d want 00876/0/12", data_out, valid_out, fill_level);
    end
    push(16'hCBA9);
    n_vec++;
    if (data_out !== 20'hA9876 || valid_out !== 1'b1 || fill_level !== 7'd28) begin
      n_err++; $display("FAIL pack_second: got %h/%b/%0d want A9876/1/28", data_out, valid_out, fill_level);
    end
  endtask

  task automatic test_fill_drain();
    logic [19:0] exp_words [4];
    exp_words[0] = 20'h21111; exp_words[1] = 20'h33222;
    exp_words[2] = 20'h44433; exp_words[3] = 20'h55554;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(16'h1111 * 16'(i));
      n_vec++;
      if (fill_level !== 7'(16 * i) || full !== (i == 5)) begin
        n_err++; $display("FAIL fill[%0d]: got %0d/%b want %0d/%b", i, fill_level, full, 16 * i, i == 5);
      end
    end
    push(16'hDEAD);
    n_vec++;
    if (overflow !== 1'b1 || fill_level !== 7'd80 || data_out !== exp_words[0]) begin
      n_err++; $display("FAIL overflow: got %b/%0d/%h want 1/80/%h", overflow, fill_level, data_out, exp_words[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (data_out !== exp_words[i]) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, exp_words[i]); end
      pop();
      n_vec++;
      if (fill_level !== 7'(60 - 20 * i) || valid_out !== (i != 3) || full !== 1'b0) begin
        n_err++; $display("FAIL drain[%0d]: got %0d/%b/%b want %0d/%b/0", i, fill_level, valid_out, full, 60 - 20 * i, i != 3);
      end
    end
    n_vec++;
    if (underflow !== 1'b0) begin n_err++; $display("FAIL underflow_early: got %b want 0", underflow); end
    pop();
    n_vec++;
    if (underflow !== 1'b1 || overflow !== 1'b1 || fill_level !== 7'd0 || data_out !== 20'h0) begin
      n_err++; $display("FAIL underflow: got %b/%b/%0d/%h want 1/1/0/00000", underflow, overflow, fill_level, data_out);
    end
    do_reset();
    n_vec++;
    if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL flag_clear: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(16'h1234);
    push(16'hABCD);
    n_vec++;
    if (data_out !== 20'hD1234 || fill_level !== 7'd32) begin
      n_err++; $display("FAIL b2b_pre: got %h/%0d want D1234/32", data_out, fill_level);
    end
    shift_out = 1'b1;
    push(16'h5A5A);
    n_vec++;
    if (data_out !== 20'h5AABC || fill_level !== 7'd28 || valid_out !== 1'b1) begin
      n_err++; $display("FAIL b2b_1: got %h/%0d/%b want 5AABC/28/1", data_out, fill_level, valid_out);
    end
    push(16'hFFFF);
    shift_out = 1'b0;
    n_vec++;
    if (data_out !== 20'hFFF5A || fill_level !== 7'd24) begin
      n_err++; $display("FAIL b2b_2: got %h/%0d want FFF5A/24", data_out, fill_level);
    end
    pop();
    n_vec++;
    if (data_out !== 20'h0000F || fill_level !== 7'd4 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL b2b_tail: got %h/%0d/%b want 0000F/4/0", data_out, fill_level, valid_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (fill_level !== 7'd0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL flush_empty: got %0d/%b want 0/0", fill_level, valid_out);
    end
    push(16'h00FF);
    flush = 1'b1;
    tick();
    n_vec++;
    if (fill_level !== 7'd20 || data_out !== 20'h000FF || valid_out !== 1'b1) begin
      n_err++; $display("FAIL flush_pad: got %0d/%h/%b want 20/000FF/1", fill_level, data_out, valid_out);
    end
    tick();
    flush = 1'b0;
    n_vec++;
    if (fill_level !== 7'd20) begin n_err++; $display("FAIL flush_full_word: got %0d want 20", fill_level); end
    do_reset();
    push(16'h00FF);
    flush = 1'b1;
    push(16'h1234);
    flush = 1'b0;
    n_vec++;
    if (fill_level !== 7'd32 || data_out !== 20'h400FF || {overflow, underflow} !== 2'b00) begin
      n_err++; $display("FAIL flush_push: got %0d/%h/%b want 32/400FF/00", fill_level, data_out, {overflow, underflow});
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
